// File: rtl/sti_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sti_pkg
// Description : Shared encodings for the STI_DAC command sequencer: serial
//               length codes, config-word bit positions, the expected-bit
//               helper and the sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sti_pkg;

  // Serial length codes carried in config[29:28]
  localparam logic [1:0] LEN_8  = 2'b00;
  localparam logic [1:0] LEN_16 = 2'b01;
  localparam logic [1:0] LEN_24 = 2'b10;
  localparam logic [1:0] LEN_32 = 2'b11;

  // Bit positions inside the packed 32-bit command word
  localparam int c_cfg_len_lsb = 28;
  localparam int c_cfg_fill    = 24;
  localparam int c_cfg_msb     = 20;
  localparam int c_cfg_low     = 16;

  // Burst bit counter width (holds up to 63, enough for a 32-bit burst)
  localparam int c_bitcnt_w = 6;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_CAPT      = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WAIT_RISE = 3'd4,
    ST_WAIT_FALL = 3'd5,
    ST_FIN       = 3'd6
  } state_t;

  // Number of so_valid cycles a burst of the given length code must last
  function automatic logic [c_bitcnt_w-1:0] exp_bits(input logic [1:0] len);
    return {1'b0, len, 3'b000} + 6'd8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/so_burst_mon.sv
`default_nettype none
// ============================================================================
// Module      : so_burst_mon
// Description : Watches one transmitter burst while armed. Before the burst
//               it counts idle cycles and flags a start timeout; during the
//               burst it counts so_valid cycles and, on the falling edge,
//               compares the count with the length requested for the entry.
// Revision    : 1.0 - initial release
// ============================================================================
module so_burst_mon
  import sti_pkg::*;
#(
  parameter int TMO_W   = 5,
  parameter int TMO_MAX = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_arm,
  input  logic       i_so_valid,
  input  logic [1:0] i_len,
  output logic       o_burst_end,
  output logic       o_tmo,
  output logic       o_mismatch
);

  // The timeout fires on the TMO_MAX-th consecutive idle cycle
  localparam logic [TMO_W-1:0]      c_tmo_last = TMO_W'(TMO_MAX - 1);
  localparam logic [c_bitcnt_w-1:0] c_bit_sat  = '1;

  logic                  r_in_burst;
  logic [TMO_W-1:0]      r_tmo_cnt;
  logic [c_bitcnt_w-1:0] r_bit_cnt;

  // Event decode: timeout before the rise, end-of-burst and length check on the fall
  always_comb begin
    o_tmo       = i_arm && !r_in_burst && !i_so_valid && (r_tmo_cnt == c_tmo_last);
    o_burst_end = i_arm && r_in_burst && !i_so_valid;
    o_mismatch  = o_burst_end && (r_bit_cnt != exp_bits(i_len));
  end

  // Counters restart whenever the monitor is disarmed; the bit count saturates
  // so an overlong burst can never wrap around into a false match.
  always_ff @(posedge clk) begin
    if (rst || !i_arm) begin
      r_in_burst <= 1'b0;
      r_tmo_cnt  <= '0;
      r_bit_cnt  <= '0;
    end else if (!r_in_burst) begin
      if (i_so_valid) begin
        r_in_burst <= 1'b1;
        r_bit_cnt  <= c_bitcnt_w'(1);
      end else begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
    end else if (i_so_valid && (r_bit_cnt != c_bit_sat)) begin
      r_bit_cnt <= r_bit_cnt + c_bitcnt_w'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sti_pi_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sti_pi_sequencer
// Description : Upstream command sequencer for the STI_DAC serial transmitter.
//               Walks a synchronous command ROM from address 0 to last_idx,
//               issues one load pulse with the pi_* fields per entry, waits
//               for each so_valid burst to finish and checks its length and
//               start latency.
// Revision    : 1.0 - initial release
// ============================================================================
module sti_pi_sequencer
  import sti_pkg::*;
#(
  parameter int ADDR_W  = 7,
  parameter int TMO_W   = 5,
  parameter int TMO_MAX = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_rd,
  input  logic [31:0]       rom_rdata,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic              tmo_err
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   r_last_idx;
  logic                w_start_acc;
  logic                w_is_last;
  logic                w_arm;
  logic                w_burst_end;
  logic                w_tmo;
  logic                w_mismatch;
  logic                w_unused_cfg;

  assign w_start_acc = (r_state == ST_IDLE) && start;
  assign w_is_last   = (r_idx == r_last_idx);
  assign w_arm       = (r_state == ST_WAIT_RISE) || (r_state == ST_WAIT_FALL);
  assign rom_addr    = r_idx;

  // Reserved config bits carry no meaning for this transmitter
  assign w_unused_cfg = ^{rom_rdata[31:30], rom_rdata[27:25], rom_rdata[23:21], rom_rdata[19:17]};

  so_burst_mon #(
    .TMO_W   (TMO_W),
    .TMO_MAX (TMO_MAX)
  ) u_mon (
    .clk         (clk),
    .rst         (reset),
    .i_arm       (w_arm),
    .i_so_valid  (so_valid),
    .i_len       (pi_length),
    .o_burst_end (w_burst_end),
    .o_tmo       (w_tmo),
    .o_mismatch  (w_mismatch)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    w_state_nxt = r_state;
    rom_rd      = 1'b0;
    load        = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy        = 1'b1;
        rom_rd      = 1'b1;
        w_state_nxt = ST_CAPT;
      end
      ST_CAPT: begin
        busy        = 1'b1;
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        busy        = 1'b1;
        load        = 1'b1;
        w_state_nxt = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        busy = 1'b1;
        if (w_tmo) begin
          w_state_nxt = ST_FIN;
        end else if (so_valid) begin
          w_state_nxt = ST_WAIT_FALL;
        end
      end
      ST_WAIT_FALL: begin
        busy = 1'b1;
        if (w_burst_end) begin
          w_state_nxt = w_is_last ? ST_FIN : ST_FETCH;
        end
      end
      ST_FIN: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Entry index: reset to 0 on start, advanced after each non-final burst
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx      <= '0;
      r_last_idx <= '0;
    end else if (w_start_acc) begin
      r_idx      <= '0;
      r_last_idx <= last_idx;
    end else if ((r_state == ST_WAIT_FALL) && w_burst_end && !w_is_last) begin
      r_idx <= r_idx + ADDR_W'(1);
    end
  end

  // Capture the ROM word one cycle after the read; fields then hold until the next capture
  always_ff @(posedge clk) begin
    if (reset) begin
      pi_data   <= '0;
      pi_length <= LEN_8;
      pi_fill   <= 1'b0;
      pi_msb    <= 1'b0;
      pi_low    <= 1'b0;
    end else if (r_state == ST_CAPT) begin
      pi_data   <= rom_rdata[15:0];
      pi_length <= rom_rdata[c_cfg_len_lsb +: 2];
      pi_fill   <= rom_rdata[c_cfg_fill];
      pi_msb    <= rom_rdata[c_cfg_msb];
      pi_low    <= rom_rdata[c_cfg_low];
    end
  end

  // pi_end rises together with the final load; an accepted start clears it
  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      pi_end <= 1'b0;
    end else if ((r_state == ST_CAPT) && w_is_last) begin
      pi_end <= 1'b1;
    end
  end

  // Sticky burst errors, cleared only by reset or an accepted start
  always_ff @(posedge clk) begin
    if (reset || w_start_acc) begin
      len_err <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      if (w_mismatch) begin
        len_err <= 1'b1;
      end
      if (w_tmo) begin
        tmo_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
